// File: rtl/press_classifier_pkg.sv
// Shared definitions for the press classifier: FSM state encoding and default tick counts.
package press_classifier_pkg;

    // Gesture FSM states.
    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StPressed  = 3'd1,
        StLongHeld = 3'd2,
        StWaitGap  = 3'd3,
        StSecond   = 3'd4
    } state_e;

    // Defaults for a 100 MHz clock; top-level wrappers may reuse these.
    localparam int unsigned DefLongTicks   = 50_000_000;
    localparam int unsigned DefGapTicks    = 25_000_000;
    localparam int unsigned DefRepeatTicks = 10_000_000;
    localparam int unsigned DefCntW        = 27;

endpackage

// File: rtl/press_timer.sv
// Clearable up-counter with an equality terminal compare against a supplied limit.
module press_timer #(
    parameter int unsigned CNT_W = 27
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: clear has priority over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == limit_i);

endmodule

// File: rtl/press_classifier.sv
// Classifies debounced button edge pulses into short, long and double presses.
// Optional macro AUTO_REPEAT_EN adds a periodic repeat_pulse while a long hold continues;
// without it repeat_pulse is tied low.
module press_classifier
    import press_classifier_pkg::*;
#(
    parameter int unsigned LONG_TICKS   = DefLongTicks,
    parameter int unsigned GAP_TICKS    = DefGapTicks,
    parameter int unsigned REPEAT_TICKS = DefRepeatTicks,
    parameter int unsigned CNT_W        = DefCntW
) (
    input  logic clk,
    input  logic reset_n,
    input  logic p_edge,
    input  logic n_edge,
    output logic short_press,
    output logic long_press,
    output logic double_press,
    output logic hold_active,
    output logic repeat_pulse
);

    // The timer starts at 0 in the first cycle of a state, so the decision cycle
    // (one before the registered pulse) sees a count of TICKS-2.
    localparam logic [CNT_W-1:0] LongLimit = CNT_W'(LONG_TICKS - 2);
    localparam logic [CNT_W-1:0] GapLimit  = CNT_W'(GAP_TICKS - 2);

    // Elaboration-time sanity check of the tick parameters.
    if (LONG_TICKS < 2 || GAP_TICKS < 2 || REPEAT_TICKS < 1) begin : g_bad_ticks
        $error("press_classifier: tick parameters below their minimum");
    end

    state_e state_q, state_d;
    logic   press_ev, release_ev;
    logic   tmr_clr, tmr_en, tmr_done;
    logic [CNT_W-1:0] tmr_limit;
    logic   short_d, short_q;
    logic   long_d, long_q;
    logic   double_d, double_q;
    logic   hold_d, hold_q;

    // Simultaneous press and release is illegal upstream; treat it as no event.
    assign press_ev   = p_edge & ~n_edge;
    assign release_ev = n_edge & ~p_edge;

    // Timer runs only while timing a press or a gap, and restarts on every state entry.
    assign tmr_en    = (state_q == StPressed) || (state_q == StWaitGap);
    assign tmr_clr   = (state_d != state_q) || !tmr_en;
    assign tmr_limit = (state_q == StWaitGap) ? GapLimit : LongLimit;

    press_timer #(
        .CNT_W (CNT_W)
    ) u_press_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (tmr_clr),
        .en_i    (tmr_en),
        .limit_i (tmr_limit),
        .done_o  (tmr_done)
    );

    // Gesture FSM next state and pulse decisions.
    always_comb begin
        state_d  = state_q;
        short_d  = 1'b0;
        long_d   = 1'b0;
        double_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (press_ev) state_d = StPressed;
            end
            StPressed: begin
                // A release on the threshold cycle beats the long press.
                if (release_ev) begin
                    state_d = StWaitGap;
                end else if (tmr_done) begin
                    long_d  = 1'b1;
                    state_d = StLongHeld;
                end
            end
            StLongHeld: begin
                if (release_ev) state_d = StIdle;
            end
            StWaitGap: begin
                if (press_ev) begin
                    state_d = StSecond;
                end else if (tmr_done) begin
                    short_d = 1'b1;
                    state_d = StIdle;
                end
            end
            StSecond: begin
                if (release_ev) begin
                    double_d = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // hold_active rises the cycle after long_press and falls the cycle after the release.
    assign hold_d = (state_q == StLongHeld) && (state_d == StLongHeld);

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            double_q <= 1'b0;
            hold_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            short_q  <= short_d;
            long_q   <= long_d;
            double_q <= double_d;
            hold_q   <= hold_d;
        end
    end

    assign short_press  = short_q;
    assign long_press   = long_q;
    assign double_press = double_q;
    assign hold_active  = hold_q;

`ifdef AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] RepLimit = CNT_W'(REPEAT_TICKS - 1);

    logic rep_in_hold, rep_clr, rep_done, rep_d, rep_q;

    // Repeat counter is zero in the long_press cycle and restarts after each pulse.
    assign rep_in_hold = (state_q == StLongHeld);
    assign rep_clr     = !rep_in_hold || rep_done;
    assign rep_d       = rep_in_hold && !release_ev && rep_done;

    press_timer #(
        .CNT_W (CNT_W)
    ) u_repeat_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (rep_clr),
        .en_i    (rep_in_hold),
        .limit_i (RepLimit),
        .done_o  (rep_done)
    );

    // Registered repeat pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rep_q <= 1'b0;
        end else begin
            rep_q <= rep_d;
        end
    end

    assign repeat_pulse = rep_q;
`else
    assign repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_press_classifier.sv
// Bench for press_classifier: a timestamp-based gesture model checked every cycle, plus
// hand-computed pulse timings per scenario. Honours AUTO_REPEAT_EN when defined.
module tb_press_classifier;

    localparam int LONG = 20;
    localparam int GAP  = 10;
    localparam int REP  = 5;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic p_edge  = 1'b0;
    logic n_edge  = 1'b0;
    logic short_press, long_press, double_press, hold_active, repeat_pulse;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int base     = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    press_classifier #(
        .LONG_TICKS   (LONG),
        .GAP_TICKS    (GAP),
        .REPEAT_TICKS (REP),
        .CNT_W        (8)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .p_edge       (p_edge),
        .n_edge       (n_edge),
        .short_press  (short_press),
        .long_press   (long_press),
        .double_press (double_press),
        .hold_active  (hold_active),
        .repeat_pulse (repeat_pulse)
    );

    // ---------------- gesture model ----------------
    // Tracks which gesture is in progress plus the absolute cycle of its defining
    // edge; pulses are due at fixed offsets from those timestamps.
    localparam int MFree  = 0;
    localparam int MFirst = 1;
    localparam int MLong  = 2;
    localparam int MGap   = 3;
    localparam int MSec   = 4;

    int   m_mode  = MFree;
    int   t_press = 0;
    int   t_rel   = 0;
    int   t_long  = 0;
    logic exp_short = 1'b0, exp_long = 1'b0, exp_dbl = 1'b0, exp_hold = 1'b0, exp_rep = 1'b0;
    logic p_ok, n_ok;

    assign p_ok = p_edge && !n_edge;
    assign n_ok = n_edge && !p_edge;

    // cyc is the cycle whose inputs are being sampled; cyc+1 is the cycle being predicted.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_mode    <= MFree;
            exp_short <= 1'b0;
            exp_long  <= 1'b0;
            exp_dbl   <= 1'b0;
            exp_hold  <= 1'b0;
            exp_rep   <= 1'b0;
        end else begin
            exp_short <= 1'b0;
            exp_long  <= 1'b0;
            exp_dbl   <= 1'b0;
            exp_hold  <= 1'b0;
            exp_rep   <= 1'b0;
            case (m_mode)
                MFree: begin
                    if (p_ok) begin
                        m_mode  <= MFirst;
                        t_press <= cyc;
                    end
                end
                MFirst: begin
                    if (n_ok) begin
                        m_mode <= MGap;
                        t_rel  <= cyc;
                    end else if (cyc + 1 == t_press + LONG) begin
                        exp_long <= 1'b1;
                        m_mode   <= MLong;
                        t_long   <= cyc + 1;
                    end
                end
                MLong: begin
                    if (n_ok) begin
                        m_mode <= MFree;
                    end else begin
                        exp_hold <= 1'b1;
`ifdef AUTO_REPEAT_EN
                        exp_rep <= ((cyc + 1 - t_long) % REP == 0);
`endif
                    end
                end
                MGap: begin
                    if (p_ok) begin
                        m_mode <= MSec;
                    end else if (cyc + 1 == t_rel + GAP) begin
                        exp_short <= 1'b1;
                        m_mode    <= MFree;
                    end
                end
                MSec: begin
                    if (n_ok) begin
                        exp_dbl <= 1'b1;
                        m_mode  <= MFree;
                    end
                end
                default: m_mode <= MFree;
            endcase
        end
    end

    // ---------------- pulse log (relative cycles) ----------------
    int n_short, f_short, n_long, f_long, n_dbl, f_dbl;
    int n_hold, f_hold, l_hold, n_rep, f_rep, l_rep;

    task automatic clear_log();
        n_short = 0; f_short = -1; n_long = 0; f_long = -1; n_dbl = 0; f_dbl = -1;
        n_hold = 0; f_hold = -1; l_hold = -1; n_rep = 0; f_rep = -1; l_rep = -1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Compare at the falling edge, log pulses, then move to just after the next rising edge.
    task automatic step();
        logic [4:0] act, exp;
        int rel;
        @(negedge clk);
        rel = cyc - base;
        act = {short_press, long_press, double_press, hold_active, repeat_pulse};
        exp = {exp_short, exp_long, exp_dbl, exp_hold, exp_rep};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL outputs at rel cycle %0d: got %b, expected %b (short,long,double,hold,repeat)",
                     rel, act, exp);
        end
        if (short_press)  begin if (n_short == 0) f_short = rel; n_short++; end
        if (long_press)   begin if (n_long == 0) f_long = rel; n_long++; end
        if (double_press) begin if (n_dbl == 0) f_dbl = rel; n_dbl++; end
        if (hold_active)  begin if (n_hold == 0) f_hold = rel; n_hold++; l_hold = rel; end
        if (repeat_pulse) begin if (n_rep == 0) f_rep = rel; n_rep++; l_rep = rel; end
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int rel);
        while (cyc < base + rel) step();
    endtask

    task automatic press_at(input int rel);
        run_to(rel);
        p_edge = 1'b1;
        step();
        p_edge = 1'b0;
    endtask

    task automatic release_at(input int rel);
        run_to(rel);
        n_edge = 1'b1;
        step();
        n_edge = 1'b0;
    endtask

    task automatic do_reset();
        p_edge  = 1'b0;
        n_edge  = 1'b0;
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
        base = cyc;
        clear_log();
    endtask

    initial begin
        clear_log();
        @(posedge clk);
        #1;
        check("reset_short", int'(short_press), 0);
        check("reset_long", int'(long_press), 0);
        check("reset_hold", int'(hold_active), 0);
        check("reset_repeat", int'(repeat_pulse), 0);

        // 1: short press
        do_reset();
        press_at(100); release_at(105); run_to(160);
        check("t1_short_count", n_short, 1);
        check("t1_short_cycle", f_short, 115);
        check("t1_other_pulses", n_long + n_dbl + n_hold, 0);

        // 2: long press then release
        do_reset();
        press_at(100); release_at(130); run_to(170);
        check("t2_long_count", n_long, 1);
        check("t2_long_cycle", f_long, 120);
        check("t2_hold_first", f_hold, 121);
        check("t2_hold_last", l_hold, 130);
        check("t2_no_short_double", n_short + n_dbl, 0);

        // 3: double press with a long second hold
        do_reset();
        press_at(100); release_at(104); press_at(110); release_at(140); run_to(170);
        check("t3_double_count", n_dbl, 1);
        check("t3_double_cycle", f_dbl, 141);
        check("t3_no_long_hold", n_long + n_hold, 0);
        check("t3_no_short", n_short, 0);

        // 4a: press exactly at gap end starts a fresh press
        do_reset();
        press_at(100); release_at(104); press_at(114); release_at(140); run_to(170);
        check("t4a_short_cycle", f_short, 114);
        check("t4a_short_count", n_short, 1);
        check("t4a_long_cycle", f_long, 134);
        check("t4a_no_double", n_dbl, 0);

        // 4b: press one cycle earlier is a double
        do_reset();
        press_at(100); release_at(104); press_at(113); release_at(118); run_to(160);
        check("t4b_double_cycle", f_dbl, 119);
        check("t4b_no_short", n_short, 0);

        // 5a: synchronous-looking reset during PRESSED
        do_reset();
        press_at(100);
        run_to(110); reset_n = 1'b0;
        run_to(112); reset_n = 1'b1;
        release_at(115); run_to(170);
        check("t5a_no_pulses", n_short + n_long + n_dbl + n_hold + n_rep, 0);

        // 5b: asynchronous reset mid-cycle during WAIT_GAP
        do_reset();
        press_at(100); release_at(103);
        run_to(107);
        #2;
        reset_n = 1'b0;
        #1;
        check("t5b_outputs_now",
              int'({short_press, long_press, double_press, hold_active, repeat_pulse}), 0);
        step(); step();
        reset_n = 1'b1;
        run_to(150);
        check("t5b_no_short", n_short, 0);

        // 5c: asynchronous reset mid-cycle during LONG_HELD drops hold at once
        do_reset();
        press_at(100);
        run_to(125);
        check("t5c_hold_before", int'(hold_active), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t5c_hold_after", int'(hold_active), 0);
        step(); step();
        reset_n = 1'b1;
        run_to(170);
        check("t5c_hold_count", n_hold, 4);
        check("t5c_no_short_double", n_short + n_dbl, 0);

        // 6: long hold with auto-repeat
        do_reset();
        press_at(100); release_at(137); run_to(170);
        check("t6_long_cycle", f_long, 120);
        check("t6_hold_count", n_hold, 17);
`ifdef AUTO_REPEAT_EN
        check("t6_repeat_count", n_rep, 3);
        check("t6_repeat_first", f_rep, 125);
        check("t6_repeat_last", l_rep, 135);
`else
        check("t6_repeat_count", n_rep, 0);
`endif

        // 7: simultaneous edges ignored while PRESSED
        do_reset();
        press_at(100);
        run_to(105);
        p_edge = 1'b1; n_edge = 1'b1;
        step();
        p_edge = 1'b0; n_edge = 1'b0;
        release_at(106); run_to(160);
        check("t7_short_cycle", f_short, 116);
        check("t7_short_count", n_short, 1);

        // 8: release on the long threshold cycle wins
        do_reset();
        press_at(100); release_at(119); run_to(170);
        check("t8_no_long", n_long, 0);
        check("t8_short_cycle", f_short, 129);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
